// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package dmem_arb_pkg;

    // Transaction phases: wait for a request, drive memory, report completion
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_N_REQ  = 2;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Rotate a requester index by one, wrapping at n
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational winner selection for the data-memory arbiter.
// Round-robin search starting at ptr; with DMEM_ARB_FIXED_PRIO_EN defined the
// search always starts at index 0 and ptr is ignored.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Pointer has no meaning under fixed priority
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // First asserted request in search order wins
    always_comb begin
        int j;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int off = 0; off < N_REQ; off++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            j = off;
`else
            j = (int'(ptr) + off) % N_REQ;
`endif
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between N_REQ requesters.
// One transaction at a time, IDLE -> ACCESS -> DONE, three cycles each.
// Memory strobes, address and write data are registered and only live in ACCESS;
// read data is sampled at the posedge closing ACCESS (memory reads on the negedge).
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [ADDR_W-1:0]       mem_endereco,
    output logic [DATA_W-1:0]       mem_escreve,
    input  logic [DATA_W-1:0]       mem_le_dado
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [N_REQ-1:0]   gnt_q, gnt_nxt;
    logic               we_q, we_nxt;

    logic [N_REQ-1:0]   ack_nxt;
    logic [DATA_W-1:0]  rdata_nxt;
    logic               mem_write_nxt, mem_read_nxt;
    logic [ADDR_W-1:0]  mem_endereco_nxt;
    logic [DATA_W-1:0]  mem_escreve_nxt;

    logic [N_REQ-1:0]   win_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (win_gnt),
        .idx   (win_idx),
        .valid (win_vld)
    );

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: a request in IDLE starts a fixed three-cycle transaction
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/next-register values; strobes default low so they only live in ACCESS
    always_comb begin
        ptr_nxt          = ptr;
        gnt_nxt          = gnt_q;
        we_nxt           = we_q;
        rdata_nxt        = rdata;
        ack_nxt          = '0;
        mem_write_nxt    = 1'b0;
        mem_read_nxt     = 1'b0;
        mem_endereco_nxt = '0;
        mem_escreve_nxt  = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_nxt          = win_gnt;
                    we_nxt           = we[win_idx];
                    mem_write_nxt    = we[win_idx];
                    mem_read_nxt     = ~we[win_idx];
                    mem_endereco_nxt = addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    mem_escreve_nxt  = wdata[int'(win_idx)*DATA_W +: DATA_W];
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    ptr_nxt          = '0;
`else
                    ptr_nxt          = IDX_W'(rr_next(int'(win_idx), N_REQ));
`endif
                end
            end
            ACCESS: begin
                ack_nxt = gnt_q;
                if (!we_q) rdata_nxt = mem_le_dado;
            end
            default: ;
        endcase
    end

    // Registered outputs, grant latch and round-robin pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr          <= '0;
            gnt_q        <= '0;
            we_q         <= 1'b0;
            ack          <= '0;
            rdata        <= '0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_endereco <= '0;
            mem_escreve  <= '0;
        end else begin
            ptr          <= ptr_nxt;
            gnt_q        <= gnt_nxt;
            we_q         <= we_nxt;
            ack          <= ack_nxt;
            rdata        <= rdata_nxt;
            mem_write    <= mem_write_nxt;
            mem_read     <= mem_read_nxt;
            mem_endereco <= mem_endereco_nxt;
            mem_escreve  <= mem_escreve_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int N = 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req, we, ack;
    logic [N*8-1:0]  addr, wdata;
    logic [7:0]      rdata, mem_endereco, mem_escreve, mem_le_dado;
    logic            busy, mem_write, mem_read;

    int checks = 0;
    int errors = 0;

    logic [7:0] memd [256];

    dmem_arbiter #(.N_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_endereco (mem_endereco),
        .mem_escreve  (mem_escreve),
        .mem_le_dado  (mem_le_dado)
    );

    always #5 clock = ~clock;

    // Memory: contents i*3, writes on posedge
    initial begin
        for (int i = 0; i < 256; i++) memd[i] = 8'(i * 3);
        forever begin
            @(posedge clock);
            if (mem_write) memd[mem_endereco] <= mem_escreve;
        end
    end

    // Memory read on the negedge
    initial begin
        mem_le_dado = 8'h00;
        forever begin
            @(negedge clock);
            if (mem_read) mem_le_dado <= memd[mem_endereco];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] we;
        logic [7:0]   a;
        logic [7:0]   d;
        logic [N-1:0] exp_ack;
        logic [7:0]   exp_rdata;
    } vec_t;

    vec_t tbl [6];

    // ---------------- reference model ----------------
    int          m_p, m_cnt, m_cur;
    logic        m_we;
    logic [7:0]  m_a, m_d;
    logic [7:0]  mref [256];
    logic [N-1:0] e_ack;
    logic [7:0]  e_rdata, e_ea, e_ee;
    logic        e_mr, e_mw, e_busy;

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // What the arbiter must present after the next posedge, given current inputs
    task automatic model_step();
        int w;
        e_mr = 1'b0; e_mw = 1'b0; e_ea = 8'h00; e_ee = 8'h00;
        if (m_cnt == 0) begin
            e_ack = '0;
            w = pick(req, m_p);
            if (w >= 0) begin
                m_cur = w; m_we = we[w]; m_a = addr[w*8 +: 8]; m_d = wdata[w*8 +: 8];
`ifndef DMEM_ARB_FIXED_PRIO_EN
                m_p = (w + 1) % N;
`endif
                m_cnt = 2;
                e_mr = ~m_we; e_mw = m_we; e_ea = m_a; e_ee = m_d;
            end
        end else if (m_cnt == 2) begin
            if (m_we) mref[m_a] = m_d;
            else      e_rdata = mref[m_a];
            e_ack = '0;
            e_ack[m_cur] = 1'b1;
            m_cnt = 1;
        end else begin
            e_ack = '0;
            m_cnt = 0;
        end
        e_busy = (m_cnt != 0);
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        req[i] = 1'b1; we[i] = w; addr[i*8 +: 8] = a; wdata[i*8 +: 8] = d;
    endtask

    initial begin
        int who;
        reset_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;

        tbl[0] = '{2'b01, 2'b00, 8'h09, 8'h00, 2'b01, 8'h1B};
        tbl[1] = '{2'b10, 2'b10, 8'h20, 8'hA5, 2'b10, 8'h1B};
        tbl[2] = '{2'b10, 2'b00, 8'h20, 8'h00, 2'b10, 8'hA5};
        tbl[3] = '{2'b01, 2'b01, 8'hFF, 8'h5A, 2'b01, 8'hA5};
        tbl[4] = '{2'b01, 2'b00, 8'hFF, 8'h00, 2'b01, 8'h5A};
        tbl[5] = '{2'b10, 2'b00, 8'h00, 8'h00, 2'b10, 8'h00};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 0);
        chk("rst_addr", 32'({mem_endereco, mem_escreve}), 0);
        reset_n = 1'b1;

        // Idle: nothing moves without requests
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle", 32'({busy, ack, mem_read, mem_write}), 0);
        end

        // Table: single transactions, full cycle-level check
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++)
                if (tbl[v].req[i]) set_req(i, tbl[v].we[i], tbl[v].a, tbl[v].d);
            @(negedge clock);
            chk("tbl_busy_access", 32'(busy), 1);
            chk("tbl_strobes", 32'({mem_read, mem_write}), 32'({~|tbl[v].we, |tbl[v].we}));
            chk("tbl_addr", 32'(mem_endereco), 32'(tbl[v].a));
            chk("tbl_ack_early", 32'(ack), 0);
            @(negedge clock);
            chk("tbl_ack", 32'(ack), 32'(tbl[v].exp_ack));
            chk("tbl_rdata", 32'(rdata), 32'(tbl[v].exp_rdata));
            chk("tbl_strobes_done", 32'({mem_read, mem_write, mem_endereco}), 0);
            req = '0;
            @(negedge clock);
            chk("tbl_idle", 32'({busy, ack}), 0);
        end

        // Late drop: req held one cycle past ack gives a second transaction
        set_req(0, 1'b0, 8'h09, 8'h00);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            chk("late_ack", 32'(ack), (c == 2 || c == 5) ? 32'h1 : 32'h0);
            if (c == 2 || c == 5) chk("late_rdata", 32'(rdata), 32'h1B);
            if (c == 4) req = '0;
        end

        // Reset mid-ACCESS write: strobe drops at once, memory untouched
        set_req(0, 1'b1, 8'h40, 8'h77);
        @(negedge clock);
        chk("abort_pre_mw", 32'(mem_write), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mw", 32'(mem_write), 0);
        chk("abort_busy_ack", 32'({busy, ack}), 0);
        chk("abort_addr", 32'(mem_endereco), 0);
        req = '0;
        @(negedge clock);
        chk("abort_mem", 32'(memd[8'h40]), 32'hC0);

        // Contention held from reset
        set_req(0, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b0, 8'h02, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c % 3 == 2) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                who = 0;
`else
                who = ((c - 2) / 3) % 2;
`endif
                chk("cont_ack", 32'(ack), 32'(1 << who));
                chk("cont_rdata", 32'(rdata), (who == 1) ? 32'h06 : 32'h03);
            end else begin
                chk("cont_ack_zero", 32'(ack), 0);
            end
        end

        // Randomized traffic against the reference model
        req = '0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) mref[i] = memd[i];
        m_p = 0; m_cnt = 0; m_cur = 0; m_we = 1'b0; m_a = '0; m_d = '0;
        e_ack = '0; e_rdata = '0; e_ea = '0; e_ee = '0; e_mr = 0; e_mw = 0; e_busy = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_ack", 32'(ack), 32'(e_ack));
            chk("rnd_busy", 32'(busy), 32'(e_busy));
            chk("rnd_strobes", 32'({mem_read, mem_write}), 32'({e_mr, e_mw}));
            chk("rnd_addr", 32'(mem_endereco), 32'(e_ea));
            chk("rnd_wdata", 32'(mem_escreve), 32'(e_ee));
            chk("rnd_rdata", 32'(rdata), 32'(e_rdata));
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) req[i] = 1'b0;
                else if (!req[i] && ($urandom % 3 == 0))
                    set_req(i, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
            end
            model_step();
            @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
